// File: rtl/video_timing_if.sv
// Raster timing bundle from video_timing_m to the pixel pipeline.
// The master modport drives it; the slave modport is used by consumers.
interface video_timing_if;
    logic [7:0] xp;
    logic [7:0] yp;
    logic       active;
    logic       display_en;
    logic       hsync;
    logic       vsync;
    logic       writable;
    logic       vblank_irq;
    logic [7:0] frame;

    modport master (
        output xp, yp, active, display_en, hsync, vsync, writable, vblank_irq, frame
    );
    modport slave (
        input  xp, yp, active, display_en, hsync, vsync, writable, vblank_irq, frame
    );
endinterface

// File: rtl/video_timing_m.sv
// 640x480@60 raster timing at a 400x525 pixel-clock grid, with 256x240 game
// coordinates and sync/display-enable delayed to line up with the mixer output.
module video_timing_m #(
    parameter int SYNC_DELAY = 1,
    parameter int X_OFFSET   = 32
) (
    input  logic          clk,
    input  logic          rst,
    video_timing_if.master vo
);
    localparam logic [9:0] XS   = 10'(X_OFFSET);
    localparam logic [9:0] XE   = 10'(X_OFFSET + 256);
    localparam logic [8:0] XOFF = 9'(X_OFFSET);

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

    logic [8:0] h;
    logic [9:0] v;
    logic [7:0] frame_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h       <= '0;
            v       <= '0;
            frame_q <= '0;
        end else if (h == 9'd399) begin
            h <= '0;
            if (v == 10'd524) begin
                v       <= '0;
                frame_q <= frame_q + 8'd1;
            end else begin
                v <= v + 10'd1;
            end
        end else begin
            h <= h + 9'd1;
        end
    end

    logic       in_x, v_vis, act;
    logic [8:0] hx;
    sync_t      sync_raw;

    always_comb begin
        in_x     = ({1'b0, h} >= XS) && ({1'b0, h} < XE);
        v_vis    = v < 10'd480;
        hx       = h - XOFF;
        // Counters sit at the visible origin in reset; keep enables low there.
        act      = in_x && v_vis && !rst;
        sync_raw = '{hs: !((h >= 9'd328) && (h <= 9'd375)),
                     vs: !((v >= 10'd490) && (v <= 10'd491)),
                     de: (h < 9'd320) && v_vis && !rst};
    end

    assign vo.active     = act;
    assign vo.xp         = act ? hx[7:0] : 8'd0;
    assign vo.yp         = act ? v[8:1]  : 8'd0;
    assign vo.writable   = v >= 10'd480;
    assign vo.vblank_irq = (h == 9'd0) && (v == 10'd480);
    assign vo.frame      = frame_q;

    generate
        if (SYNC_DELAY == 0) begin : g_nodly
            assign vo.hsync      = sync_raw.hs;
            assign vo.vsync      = sync_raw.vs;
            assign vo.display_en = sync_raw.de;
        end else begin : g_dly
            sync_t [SYNC_DELAY-1:0] dly_pipe;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_DELAY; i++) dly_pipe[i] <= SYNC_RST;
                end else begin
                    dly_pipe[0] <= sync_raw;
                    for (int i = 1; i < SYNC_DELAY; i++) dly_pipe[i] <= dly_pipe[i-1];
                end
            end

            assign vo.hsync      = dly_pipe[SYNC_DELAY-1].hs;
            assign vo.vsync      = dly_pipe[SYNC_DELAY-1].vs;
            assign vo.display_en = dly_pipe[SYNC_DELAY-1].de;
        end
    endgenerate
endmodule

// File: tb/tb_video_timing_m.sv
// Directed bench for video_timing_m: default instance plus a SYNC_DELAY=3 instance.
module tb_video_timing_m;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    video_timing_if vif0 ();
    video_timing_if vif3 ();

    video_timing_m #(.SYNC_DELAY(1), .X_OFFSET(32)) dut0 (.clk(clk), .rst(rst), .vo(vif0));
    video_timing_m #(.SYNC_DELAY(3), .X_OFFSET(32)) dut3 (.clk(clk), .rst(rst), .vo(vif3));

    always #5 clk = ~clk;

    // Raster position expected for the current cycle (valid between posedges).
    int th = 0, tv = 0, tf = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            th <= 0; tv <= 0; tf <= 0;
        end else if (th == 399) begin
            th <= 0;
            if (tv == 524) begin tv <= 0; tf <= (tf + 1) % 256; end
            else tv <= tv + 1;
        end else begin
            th <= th + 1;
        end
    end

    task automatic wait_to(input int hh, input int vv, input int ff, input int bound);
        int n = 0;
        while (!(th == hh && tv == vv && (ff < 0 || tf == ff)) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) begin
            checks++; errors++;
            $display("FAIL wait_to(%0d,%0d,%0d): timed out at (%0d,%0d)", hh, vv, ff, th, tv);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({vif0.xp, vif0.yp, vif0.active, vif0.display_en, vif0.hsync, vif0.vsync,
             vif0.writable, vif0.vblank_irq, vif0.frame} !== {8'd0, 8'd0, 7'b0001100, 8'd0}) begin
            errors++;
            $display("FAIL reset_d1: xp=%0d yp=%0d act=%b de=%b hs=%b vs=%b wr=%b irq=%b fr=%0d",
                     vif0.xp, vif0.yp, vif0.active, vif0.display_en, vif0.hsync, vif0.vsync,
                     vif0.writable, vif0.vblank_irq, vif0.frame);
        end
        checks++;
        if ({vif3.display_en, vif3.hsync, vif3.vsync, vif3.active} !== 4'b0110) begin
            errors++;
            $display("FAIL reset_d3: de/hs/vs/act=%b required 0110",
                     {vif3.display_en, vif3.hsync, vif3.vsync, vif3.active});
        end
        rst = 1'b0;
    endtask

    // One full frame from (0,0) on the SYNC_DELAY=1 instance.
    task automatic test_frame();
        int hfalls = 0, hlow = 0, run = 0, badruns = 0;
        int vfalls = 0, vlow = 0, vfh = -1, vfv = -1;
        int wr = 0, irq = 0, irqh = -1, irqv = -1, de = 0;
        logic hp = 1'b1, vp = 1'b1;
        for (int i = 0; i < 210000; i++) begin
            if (!vif0.hsync) begin hlow++; run++; end
            if (hp && !vif0.hsync) hfalls++;
            if (!hp && vif0.hsync) begin if (run != 48) badruns++; run = 0; end
            if (!vif0.vsync) vlow++;
            if (vp && !vif0.vsync) begin vfalls++; vfh = th; vfv = tv; end
            if (vif0.writable) wr++;
            if (vif0.display_en) de++;
            if (vif0.vblank_irq) begin irq++; irqh = th; irqv = tv; end
            hp = vif0.hsync;
            vp = vif0.vsync;
            @(negedge clk);
        end
        checks++; if (vif0.frame !== 8'd1) begin errors++; $display("FAIL frame_count: got %0d required 1", vif0.frame); end
        checks++; if (hfalls != 525) begin errors++; $display("FAIL hsync_pulses: got %0d required 525", hfalls); end
        checks++; if (hlow != 25200) begin errors++; $display("FAIL hsync_low: got %0d required 25200", hlow); end
        checks++; if (badruns != 0) begin errors++; $display("FAIL hsync_width: %0d pulses not 48 wide", badruns); end
        checks++; if (vfalls != 1) begin errors++; $display("FAIL vsync_pulses: got %0d required 1", vfalls); end
        checks++; if (vlow != 800) begin errors++; $display("FAIL vsync_low: got %0d required 800", vlow); end
        // One cycle of delay: the fall at h=0,v=490 appears at h=1.
        checks++; if (vfh != 1 || vfv != 490) begin errors++; $display("FAIL vsync_start: at (%0d,%0d) required (1,490)", vfh, vfv); end
        checks++; if (wr != 18000) begin errors++; $display("FAIL writable_cycles: got %0d required 18000", wr); end
        checks++; if (de != 153600) begin errors++; $display("FAIL display_en_cycles: got %0d required 153600", de); end
        checks++; if (irq != 1 || irqh != 0 || irqv != 480) begin
            errors++; $display("FAIL vblank_irq: count %0d at (%0d,%0d) required 1 at (0,480)", irq, irqh, irqv);
        end
    endtask

    task automatic test_decode_top();
        int ph[4] = '{32, 287, 32, 288};
        int pv[4] = '{0, 1, 2, 2};
        int ex[4] = '{0, 255, 0, 0};
        int ey[4] = '{0, 0, 1, 0};
        int ea[4] = '{1, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            wait_to(ph[i], pv[i], -1, 250000);
            checks++;
            if (vif0.xp !== 8'(ex[i]) || vif0.yp !== 8'(ey[i]) || vif0.active !== 1'(ea[i])) begin
                errors++;
                $display("FAIL decode(%0d,%0d): xp/yp/act=%0d/%0d/%b required %0d/%0d/%0d",
                         ph[i], pv[i], vif0.xp, vif0.yp, vif0.active, ex[i], ey[i], ea[i]);
            end
        end
    endtask

    task automatic test_delay();
        wait_to(320, 10, -1, 250000);
        checks++; if (vif0.display_en !== 1'b1) begin errors++; $display("FAIL de_d1_hold: got %b required 1", vif0.display_en); end
        @(negedge clk);
        checks++; if (vif0.display_en !== 1'b0) begin errors++; $display("FAIL de_d1_fall: got %b required 0", vif0.display_en); end
        @(negedge clk);
        checks++; if (vif3.display_en !== 1'b1) begin errors++; $display("FAIL de_d3_hold: got %b required 1", vif3.display_en); end
        @(negedge clk);
        checks++; if (vif3.display_en !== 1'b0) begin errors++; $display("FAIL de_d3_fall: got %b required 0", vif3.display_en); end
        wait_to(328, 10, -1, 1000);
        checks++; if (vif0.hsync !== 1'b1) begin errors++; $display("FAIL hs_d1_hold: got %b required 1", vif0.hsync); end
        @(negedge clk);
        checks++; if (vif0.hsync !== 1'b0) begin errors++; $display("FAIL hs_d1_fall: got %b required 0", vif0.hsync); end
        @(negedge clk);
        checks++; if (vif3.hsync !== 1'b1) begin errors++; $display("FAIL hs_d3_hold: got %b required 1", vif3.hsync); end
        @(negedge clk);
        checks++; if (vif3.hsync !== 1'b0) begin errors++; $display("FAIL hs_d3_fall: got %b required 0", vif3.hsync); end
    endtask

    task automatic test_decode_bottom();
        wait_to(31, 479, -1, 250000);
        checks++; if ({vif0.xp, vif0.yp, vif0.active} !== 17'd0) begin
            errors++; $display("FAIL decode(31,479): xp/yp/act=%0d/%0d/%b required 0/0/0", vif0.xp, vif0.yp, vif0.active);
        end
        @(negedge clk);
        checks++; if (vif0.xp !== 8'd0 || vif0.yp !== 8'd239 || vif0.active !== 1'b1) begin
            errors++; $display("FAIL decode(32,479): xp/yp/act=%0d/%0d/%b required 0/239/1", vif0.xp, vif0.yp, vif0.active);
        end
        wait_to(399, 479, -1, 1000);
        checks++; if (vif0.writable !== 1'b0 || vif0.vblank_irq !== 1'b0) begin
            errors++; $display("FAIL vblank_pre: wr/irq=%b%b required 00", vif0.writable, vif0.vblank_irq);
        end
        @(negedge clk);
        checks++; if (vif0.writable !== 1'b1 || vif0.vblank_irq !== 1'b1) begin
            errors++; $display("FAIL vblank_start: wr/irq=%b%b required 11", vif0.writable, vif0.vblank_irq);
        end
        @(negedge clk);
        checks++; if (vif0.writable !== 1'b1 || vif0.vblank_irq !== 1'b0) begin
            errors++; $display("FAIL vblank_next: wr/irq=%b%b required 10", vif0.writable, vif0.vblank_irq);
        end
    endtask

    task automatic test_mid_reset();
        wait_to(200, 300, 5, 1000000);
        checks++; if (vif0.frame !== 8'd5 || vif0.xp !== 8'd168 || vif0.yp !== 8'd150 || vif0.active !== 1'b1) begin
            errors++; $display("FAIL pre_reset(200,300): fr/xp/yp/act=%0d/%0d/%0d/%b required 5/168/150/1",
                               vif0.frame, vif0.xp, vif0.yp, vif0.active);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({vif0.xp, vif0.yp, vif0.active, vif0.display_en, vif0.hsync, vif0.vsync,
             vif0.writable, vif0.vblank_irq, vif0.frame} !== {8'd0, 8'd0, 7'b0001100, 8'd0}) begin
            errors++;
            $display("FAIL async_reset: xp=%0d yp=%0d act=%b de=%b hs=%b vs=%b wr=%b irq=%b fr=%0d",
                     vif0.xp, vif0.yp, vif0.active, vif0.display_en, vif0.hsync, vif0.vsync,
                     vif0.writable, vif0.vblank_irq, vif0.frame);
        end
        checks++; if ({vif3.display_en, vif3.hsync, vif3.vsync} !== 3'b011) begin
            errors++; $display("FAIL async_reset_d3: de/hs/vs=%b required 011", {vif3.display_en, vif3.hsync, vif3.vsync});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (vif0.frame !== 8'd0 || vif0.display_en !== 1'b1 || vif3.display_en !== 1'b0 || vif3.hsync !== 1'b1) begin
            errors++; $display("FAIL restart: fr=%0d de1=%b de3=%b hs3=%b required 0/1/0/1",
                               vif0.frame, vif0.display_en, vif3.display_en, vif3.hsync);
        end
        wait_to(32, 0, 0, 1000);
        checks++; if (vif0.xp !== 8'd0 || vif0.yp !== 8'd0 || vif0.active !== 1'b1 || vif0.writable !== 1'b0) begin
            errors++; $display("FAIL restart(32,0): xp/yp/act/wr=%0d/%0d/%b/%b required 0/0/1/0",
                               vif0.xp, vif0.yp, vif0.active, vif0.writable);
        end
        @(negedge clk);
        checks++; if (vif0.xp !== 8'd1) begin errors++; $display("FAIL restart(33,0): xp=%0d required 1", vif0.xp); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_decode_top();
        test_delay();
        test_decode_bottom();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
